xor_stim_gen: RTL

//  Clocked stimulus source for the 4-input XOR/inverter block. Drives its a,b,c,d

---
 rtl/xor_stim_gen_if.sv | 43 ++++
 rtl/xor_stim_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/xor_stim_gen_if.sv
// Handshake/pattern bundle between the stimulus controller and xor_stim_gen.
// PARITY_CHECK_EN adds the returned XOR bit and the error reporting signals.
interface xor_stim_gen_if #(
    parameter int PW = 8,
    parameter int SW = 4
);
    logic          start;
    logic          stop;
    logic          mode_gray;
    logic [PW-1:0] period;
    logic [SW-1:0] sweeps;
    logic          a;
    logic          b;
    logic          c;
    logic          d;
    logic          valid;
    logic          busy;
    logic          done;
    logic [3:0]    pat_idx;
`ifdef PARITY_CHECK_EN
    logic          dut_x;
    logic [7:0]    err_cnt;
    logic          err;

    modport master (
        output start, stop, mode_gray, period, sweeps, dut_x,
        input  a, b, c, d, valid, busy, done, pat_idx, err_cnt, err
    );
    modport slave (
        input  start, stop, mode_gray, period, sweeps, dut_x,
        output a, b, c, d, valid, busy, done, pat_idx, err_cnt, err
    );
`else
    modport master (
        output start, stop, mode_gray, period, sweeps,
        input  a, b, c, d, valid, busy, done, pat_idx
    );
    modport slave (
        input  start, stop, mode_gray, period, sweeps,
        output a, b, c, d, valid, busy, done, pat_idx
    );
`endif
endinterface

// File: rtl/xor_stim_gen.sv
// Timed binary/Gray 4-bit sweep source for the XOR/inverter block.
// Define PARITY_CHECK_EN to add the returned-XOR mismatch checker.
module xor_stim_gen #(
    parameter int PW = 8,
    parameter int SW = 4
) (
    input logic          clk,
    input logic          rst_n,
    xor_stim_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [3:0]    idx, idx_nx;
    logic [3:0]    pat, pat_nx;
    logic [PW-1:0] hcnt, hcnt_nx;
    logic [PW-1:0] per_q, per_nx;
    logic [SW-1:0] scnt, scnt_nx;
    logic [SW-1:0] swp_q, swp_nx;
    logic          gray_q, gray_nx;
    logic          valid_q, valid_nx;
    logic [PW-1:0] peff;
    logic          last_hold;
    logic          last_sweep;
    logic          accept;

    function automatic logic [3:0] enc(input logic [3:0] v, input logic g);
        return g ? (v ^ (v >> 1)) : v;
    endfunction

    assign peff       = (per_q == '0) ? PW'(1) : per_q;
    assign last_hold  = (hcnt == peff - PW'(1));
    // sweep counter tops out at swp_q-1, so 2^SW-1 never overflows
    assign last_sweep = (swp_q != '0) && (scnt == swp_q - SW'(1));
    assign accept     = (state == IDLE) && bus.start && !bus.stop;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        pat_nx   = pat;
        hcnt_nx  = hcnt;
        per_nx   = per_q;
        scnt_nx  = scnt;
        swp_nx   = swp_q;
        gray_nx  = gray_q;
        valid_nx = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = RUN;
                    per_nx   = bus.period;
                    swp_nx   = bus.sweeps;
                    gray_nx  = bus.mode_gray;
                    idx_nx   = 4'd0;
                    pat_nx   = 4'd0;
                    hcnt_nx  = '0;
                    scnt_nx  = '0;
                    valid_nx = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_nx = IDLE;
                    idx_nx   = 4'd0;
                    pat_nx   = 4'd0;
                    hcnt_nx  = '0;
                end else if (last_hold) begin
                    hcnt_nx = '0;
                    if (idx == 4'hF && last_sweep) begin
                        state_nx = DONE;
                        idx_nx   = 4'd0;
                        pat_nx   = 4'd0;
                    end else begin
                        idx_nx   = idx + 4'd1;
                        pat_nx   = enc(idx + 4'd1, gray_q);
                        valid_nx = 1'b1;
                        if (idx == 4'hF)
                            scnt_nx = scnt + SW'(1);
                    end
                end else begin
                    hcnt_nx = hcnt + PW'(1);
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 4'd0;
            pat     <= 4'd0;
            hcnt    <= '0;
            per_q   <= '0;
            scnt    <= '0;
            swp_q   <= '0;
            gray_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            pat     <= pat_nx;
            hcnt    <= hcnt_nx;
            per_q   <= per_nx;
            scnt    <= scnt_nx;
            swp_q   <= swp_nx;
            gray_q  <= gray_nx;
            valid_q <= valid_nx;
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = pat;
    assign bus.valid   = valid_q;
    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.pat_idx = idx;

`ifdef PARITY_CHECK_EN
    logic [7:0] errc, errc_nx;
    logic       err_q, err_nx;

    always_comb begin
        errc_nx = errc;
        err_nx  = err_q;
        if (accept) begin
            errc_nx = 8'd0;
            err_nx  = 1'b0;
        end else if (state == RUN && last_hold && (bus.dut_x != ^pat)) begin
            if (errc != 8'hFF)
                errc_nx = errc + 8'd1;
            err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            errc  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            errc  <= errc_nx;
            err_q <= err_nx;
        end
    end

    assign bus.err_cnt = errc;
    assign bus.err     = err_q;
`endif
endmodule
